addr_mode_unit: RTL
===================

Name: addr_mode_unit

Overview:
Parametrised, sequential operand-resolution stage of the 16-bit CPU, placed between decode and register-file writeback.
- Resolves four addressing modes: register (MOV), immediate (MVI), direct (LDA) and register-indirect (LDAX, new).
- Direct and indirect modes fetch from data memory over a req/ack port and are bounded by a timeout.
- Valid/ready handshakes on the input and writeback sides; illegal opcodes are flagged, not silently zeroed.

Parameters:
DATA_W, 16, data and memory-address width
REG_AW, 3, register address width
OPC_W, 4, opcode width
ACC_ADDR, 0, accumulator register index (LDA/LDAX destination)
MEM_TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decoded instruction present
in_ready  out  1  unit can accept an instruction
in_opcode  in  OPC_W  decoded opcode
in_op1_reg  in  REG_AW  destination register field
in_op2_data  in  DATA_W  register-file read value of op2 register
in_imm  in  DATA_W  immediate / direct address field
mem_req  out  1  memory read request
mem_addr  out  DATA_W  memory read address
mem_ack  in  1  read data valid this cycle
mem_rdata  in  DATA_W  read data
wb_valid  out  1  writeback pending
wb_ready  in  1  register file accepts writeback
wb_regaddr  out  REG_AW  destination register
wb_data  out  DATA_W  value to write
err_illegal  out  1  one-cycle pulse: unsupported opcode
err_timeout  out  1  one-cycle pulse: memory timeout

Behaviour:
- One clock; reset is asynchronous and active-low: clk, rst_n.
- Reset values: state IDLE; in_ready 1; mem_req 0; mem_addr 0; wb_valid 0; wb_regaddr 0; wb_data 0; err_* 0; timeout counter 0.
- FSM states: IDLE, MEM_REQ, WB.
- Input handshake: an instruction is accepted when in_valid && in_ready. in_ready = (state == IDLE).
- Accept in IDLE, by opcode:
  - 4'b1011 MOV: wb_data <= in_op2_data, wb_regaddr <= in_op1_reg, go to WB.
  - 4'b1100 MVI: wb_data <= in_imm, wb_regaddr <= in_op1_reg, go to WB.
  - 4'b1101 LDA: mem_addr <= in_imm, wb_regaddr <= ACC_ADDR, mem_req <= 1, go to MEM_REQ.
  - 4'b1110 LDAX: mem_addr <= in_op2_data, wb_regaddr <= ACC_ADDR, mem_req <= 1, go to MEM_REQ.
  - Any other opcode: err_illegal pulses 1 the next cycle; stay in IDLE; no writeback.
- MEM_REQ:
  - mem_req and mem_addr are held stable; the counter increments each cycle.
  - On mem_ack: wb_data <= mem_rdata, mem_req <= 0, counter cleared, go to WB.
  - If the counter reaches MEM_TIMEOUT without ack: mem_req <= 0, err_timeout pulses 1, no writeback, go to IDLE.
  - If ack arrives in the same cycle the counter reaches MEM_TIMEOUT, the ack wins.
- WB:
  - wb_valid = 1; wb_regaddr and wb_data are held stable until wb_ready.
  - On wb_valid && wb_ready: go to IDLE; in_ready returns 1 the next cycle.
- Latency from the accept cycle N:
  - MOV/MVI: wb_valid at N+1.
  - LDA/LDAX: mem_req at N+1; wb_valid one cycle after the ack cycle.
- Throughput: one instruction in flight; no pipelining.
- mem_ack outside MEM_REQ is ignored.
- Widths: all data paths are DATA_W with no truncation. ACC_ADDR is zero-extended into wb_regaddr.
- rst_n asserted mid-operation (any state) returns everything to reset values immediately. Any pending writeback or request is dropped; mem_req deasserts asynchronously.

Decomposition:
- Package addr_mode_pkg holds:
  - opcode constants OPC_MOV=4'b1011, OPC_MVI=4'b1100, OPC_LDA=4'b1101, OPC_LDAX=4'b1110
  - enum am_state_t {IDLE, MEM_REQ, WB}
  - a function is_mem_mode(opcode)
- Sub-module am_timeout_ctr: counter with clear, enable and a terminal-count flag, parametrised by MEM_TIMEOUT. Everything else stays in the top module.

Test Plan:
- Reset then MOV: in_op1_reg=3, in_op2_data=16'hA5A5 at cycle N, wb_ready=1 -> wb_valid at N+1 with wb_regaddr=3, wb_data=16'hA5A5; in_ready=1 at N+2.
- MVI with writeback backpressure: in_imm=16'h1234, wb_ready held 0 for 4 cycles -> wb_valid and wb_data=16'h1234 stable for all 4 cycles; one write on release; in_valid ignored while in_ready=0.
- LDA: in_imm=16'h0040, mem_ack after 3 cycles with mem_rdata=16'hBEEF -> mem_addr=16'h0040 held for all 3 cycles; wb_regaddr=0, wb_data=16'hBEEF one cycle after ack.
- LDAX with timeout: in_op2_data=16'h0100, mem_ack never asserted, MEM_TIMEOUT=15 -> err_timeout single pulse, mem_req drops, no wb_valid, in_ready back to 1. Repeat with ack in the terminal cycle -> writeback happens, no error.
- Illegal opcode 4'b0011 -> err_illegal one-cycle pulse, no wb_valid, no mem_req. Then assert rst_n=0 mid MEM_REQ -> mem_req=0 asynchronously; all outputs at reset values.

Source files
------------

// File: rtl/addr_mode_pkg.sv
// Shared opcodes, FSM state type and decode helper
// for the operand-resolution stage.
package addr_mode_pkg;

    localparam logic [3:0] OPC_MOV  = 4'b1011;
    localparam logic [3:0] OPC_MVI  = 4'b1100;
    localparam logic [3:0] OPC_LDA  = 4'b1101;
    localparam logic [3:0] OPC_LDAX = 4'b1110;

    typedef enum logic [1:0] {
        IDLE,
        MEM_REQ,
        WB
    } am_state_t;

    function automatic logic is_mem_mode(input logic [3:0] opc);
        return (opc == OPC_LDA) || (opc == OPC_LDAX);
    endfunction

endpackage

// File: rtl/addr_mode_if.sv
// Decode-side, memory-side and writeback-side signals
// of the operand-resolution stage.
interface addr_mode_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int OPC_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OPC_W-1:0]  in_opcode;
    logic [REG_AW-1:0] in_op1_reg;
    logic [DATA_W-1:0] in_op2_data;
    logic [DATA_W-1:0] in_imm;
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_AW-1:0] wb_regaddr;
    logic [DATA_W-1:0] wb_data;
    logic              err_illegal;
    logic              err_timeout;

    modport slave (
        input  in_valid, in_opcode, in_op1_reg,
        input  in_op2_data, in_imm,
        input  mem_ack, mem_rdata, wb_ready,
        output in_ready, mem_req, mem_addr,
        output wb_valid, wb_regaddr, wb_data,
        output err_illegal, err_timeout
    );

    modport master (
        output in_valid, in_opcode, in_op1_reg,
        output in_op2_data, in_imm,
        output mem_ack, mem_rdata, wb_ready,
        input  in_ready, mem_req, mem_addr,
        input  wb_valid, wb_regaddr, wb_data,
        input  err_illegal, err_timeout
    );

endinterface

// File: rtl/am_timeout_ctr.sv
// Memory wait counter; tc marks the last cycle a
// request may still be acknowledged.
module am_timeout_ctr #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt;

    assign tc = (cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/addr_mode_unit.sv
// Operand-resolution stage: register, immediate,
// direct and register-indirect addressing.
module addr_mode_unit
    import addr_mode_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int REG_AW      = 3,
    parameter int OPC_W       = 4,
    parameter int ACC_ADDR    = 0,
    parameter int MEM_TIMEOUT = 15
) (
    input logic        clk,
    input logic        rst_n,
    addr_mode_if.slave bus
);

    localparam logic [REG_AW-1:0] ACC = REG_AW'(ACC_ADDR);

    am_state_t state;
    am_state_t state_nx;

    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] wb_data_q;
    logic [REG_AW-1:0] wb_reg_q;
    logic              err_ill_q;
    logic              err_to_q;

    logic [3:0] opc;
    logic       opc_fit;
    logic       is_mov;
    logic       is_mvi;
    logic       is_lda;
    logic       is_ldax;
    logic       is_mem;
    logic       legal;
    logic       accept;
    logic       in_mem;
    logic       ack;
    logic       tc;

    // Upper opcode bits, if any, must be zero to match.
    assign opc     = bus.in_opcode[3:0];
    assign opc_fit = (bus.in_opcode == OPC_W'(opc));
    assign is_mem  = opc_fit && is_mem_mode(opc);

    always_comb begin
        is_mov  = 1'b0;
        is_mvi  = 1'b0;
        is_lda  = 1'b0;
        is_ldax = 1'b0;
        unique case (1'b1)
            opc_fit && (opc == OPC_MOV):  is_mov  = 1'b1;
            opc_fit && (opc == OPC_MVI):  is_mvi  = 1'b1;
            opc_fit && (opc == OPC_LDA):  is_lda  = 1'b1;
            opc_fit && (opc == OPC_LDAX): is_ldax = 1'b1;
            default: ;
        endcase
    end

    assign legal  = is_mov | is_mvi | is_lda | is_ldax;
    assign accept = bus.in_valid && (state == IDLE);
    assign in_mem = (state == MEM_REQ);
    assign ack    = in_mem && bus.mem_ack;

    am_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (!in_mem || bus.mem_ack || tc),
        .en   (in_mem),
        .tc   (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept && (is_mov || is_mvi)) begin
                    state_nx = WB;
                end else if (accept && is_mem) begin
                    state_nx = MEM_REQ;
                end
            end
            MEM_REQ: begin
                // An ack in the terminal cycle still wins.
                if (bus.mem_ack) begin
                    state_nx = WB;
                end else if (tc) begin
                    state_nx = IDLE;
                end
            end
            WB: begin
                if (bus.wb_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q <= '0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            err_ill_q  <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            err_ill_q <= accept && !legal;
            err_to_q  <= in_mem && !bus.mem_ack && tc;
            if (accept) begin
                unique case (1'b1)
                    is_mov: begin
                        wb_data_q <= bus.in_op2_data;
                        wb_reg_q  <= bus.in_op1_reg;
                    end
                    is_mvi: begin
                        wb_data_q <= bus.in_imm;
                        wb_reg_q  <= bus.in_op1_reg;
                    end
                    is_lda: begin
                        mem_addr_q <= bus.in_imm;
                        wb_reg_q   <= ACC;
                    end
                    is_ldax: begin
                        mem_addr_q <= bus.in_op2_data;
                        wb_reg_q   <= ACC;
                    end
                    default: ;
                endcase
            end
            if (ack) begin
                wb_data_q <= bus.mem_rdata;
            end
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.mem_req     = in_mem;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.wb_valid    = (state == WB);
    assign bus.wb_regaddr  = wb_reg_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.err_illegal = err_ill_q;
    assign bus.err_timeout = err_to_q;

endmodule
